rv32_mem_arbiter: RTL and testbench

Two-requester arbiter that shares one single-port, byte-enabled, 1-cycle-read-latency block RAM between the RV32I instruction-fetch port and the load/store port. It sits between the core's fetch/LSU front ends and the BRAM. It grants at most one access per cycle and routes the registered read data back to the owning requester. Data accesses normally win, and a bounded-starvation counter guarantees fetch progress.

---
 rtl/rv32_mem_arbiter.sv | 91 +++++++++
 tb/tb_rv32_mem_arbiter.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/rv32_mem_arbiter.sv
// rv32_mem_arbiter: shares one single-port, byte-enabled BRAM (1-cycle read
// latency) between the instruction-fetch port and the load/store port.
// Data accesses normally win. A starvation counter caps how many data grants
// in a row can go by while fetch is waiting. Read data is routed back to
// whichever port owned the access in the previous cycle.
module rv32_mem_arbiter #(
  parameter int unsigned FAIR_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic        i_gnt,
  output logic        i_rvalid,
  output logic [31:0] i_rdata,
  input  logic        d_req,
  input  logic [3:0]  d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wd,
  output logic        d_gnt,
  output logic        d_rvalid,
  output logic [31:0] d_rdata,
  output logic [3:0]  m_we,
  output logic [31:0] m_addr,
  output logic [31:0] m_wd,
  input  logic [31:0] m_rd
);

  localparam logic [3:0] LIMIT = 4'(FAIR_LIMIT);

  logic [3:0] starve_cnt_q, starve_cnt_d;
  logic       rsp_v_q, rsp_v_d;
  logic       rsp_sel_q, rsp_sel_d;

  // Grant selection: data wins unless fetch has waited LIMIT data grants.
  // Both grants are held low during reset so no access can start.
  always_comb begin
    i_gnt = 1'b0;
    d_gnt = 1'b0;
    if (!rst) begin
      if (d_req && (!i_req || (starve_cnt_q < LIMIT))) begin
        d_gnt = 1'b1;
      end else if (i_req) begin
        i_gnt = 1'b1;
      end
    end
  end

  // BRAM drive: the data payload only reaches the BRAM on a data grant, so
  // writes are impossible without d_gnt. Idle cycles present the fetch address.
  always_comb begin
    m_addr = d_gnt ? d_addr : i_addr;
    m_we   = d_gnt ? d_we   : 4'b0000;
    m_wd   = d_gnt ? d_wd   : 32'h0000_0000;
  end

  // Next state for the starvation counter and the response tracker.
  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (!i_req || i_gnt) begin
      starve_cnt_d = 4'd0;
    end else if (d_gnt && (starve_cnt_q < LIMIT)) begin
      starve_cnt_d = starve_cnt_q + 4'd1;
    end
    rsp_v_d   = i_gnt | d_gnt;
    rsp_sel_d = d_gnt;
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      starve_cnt_q <= 4'd0;
      rsp_v_q      <= 1'b0;
      rsp_sel_q    <= 1'b0;
    end else begin
      starve_cnt_q <= starve_cnt_d;
      rsp_v_q      <= rsp_v_d;
      rsp_sel_q    <= rsp_sel_d;
    end
  end

  // Response routing. A response pending when reset rises is dropped, so the
  // valids are also masked by rst in that first reset cycle.
  always_comb begin
    i_rvalid = rsp_v_q && !rsp_sel_q && !rst;
    d_rvalid = rsp_v_q &&  rsp_sel_q && !rst;
    i_rdata  = m_rd;
    d_rdata  = m_rd;
  end

endmodule

// File: tb/tb_rv32_mem_arbiter.sv
// Bench for rv32_mem_arbiter: a BRAM model with read-before-write, a directed
// driver that checks grants and pushes expected responses, and a monitor that
// pops and checks responses when they come due.
module tb_rv32_mem_arbiter;

  localparam int FAIR_LIMIT = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_req, d_req;
  logic [31:0] i_addr, d_addr, d_wd;
  logic [3:0]  d_we;
  logic        i_gnt, d_gnt, i_rvalid, d_rvalid;
  logic [31:0] i_rdata, d_rdata;
  logic [3:0]  m_we;
  logic [31:0] m_addr, m_wd;
  logic [31:0] m_rd = 32'h0;

  always #5 clk = ~clk;

  rv32_mem_arbiter #(.FAIR_LIMIT(FAIR_LIMIT)) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt),
    .i_rvalid(i_rvalid), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wd(d_wd),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .m_we(m_we), .m_addr(m_addr), .m_wd(m_wd), .m_rd(m_rd)
  );

  // BRAM model: 256 words, byte enables, 1-cycle read, read-before-write.
  logic [31:0] mem [0:255];
  bit          loaded = 1'b0;
  always @(posedge clk) begin
    logic [31:0] w;
    if (!loaded) begin
      for (int i = 0; i < 256; i++) mem[i] = 32'hA000_0000 + 32'(i);
      mem[0]  = 32'h0000_0011;
      mem[1]  = 32'h0000_0022;
      mem[2]  = 32'h0000_0033;
      mem[16] = 32'h1234_5678;
      mem[32] = 32'hCAFE_F00D;
      loaded  = 1'b1;
    end
    w = mem[m_addr[9:2]];
    m_rd <= w;
    for (int b = 0; b < 4; b++) if (m_we[b]) w[8*b +: 8] = m_wd[8*b +: 8];
    mem[m_addr[9:2]] = w;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_pass  = 0;
  int n_total = 0;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %08h expected %08h (cycle %0d)", name, act, exp, cyc);
  endfunction

  typedef struct {
    int          due;
    logic [31:0] data;
  } rsp_t;
  rsp_t iq[$];
  rsp_t dq[$];

  // Monitor: each cycle, a port's rvalid must be high exactly when its oldest
  // expected response is due, and then the data must match.
  always @(negedge clk) begin
    bit ie, de;
    ie = (iq.size() > 0) && (iq[0].due == cyc);
    de = (dq.size() > 0) && (dq[0].due == cyc);
    chk("i_rvalid", 32'(i_rvalid), 32'(ie));
    chk("d_rvalid", 32'(d_rvalid), 32'(de));
    if (ie) begin
      chk("i_rdata", i_rdata, iq[0].data);
      void'(iq.pop_front());
    end
    if (de) begin
      chk("d_rdata", d_rdata, dq[0].data);
      void'(dq.pop_front());
    end
  end

  // One cycle of stimulus: drive, check grants and BRAM drive mid-cycle,
  // queue the expected response for the following cycle.
  task automatic step(input bit r, input bit ir, input logic [31:0] ia,
                      input bit dr, input logic [3:0] dwe, input logic [31:0] da,
                      input logic [31:0] dwd, input bit ei, input bit ed,
                      input logic [31:0] iv, input logic [31:0] dv,
                      input bit drop, input string tag);
    rst = r; i_req = ir; i_addr = ia; d_req = dr; d_we = dwe; d_addr = da; d_wd = dwd;
    @(negedge clk);
    chk({tag, " i_gnt"}, 32'(i_gnt), 32'(ei));
    chk({tag, " d_gnt"}, 32'(d_gnt), 32'(ed));
    chk({tag, " m_we"}, 32'(m_we), ed ? 32'(dwe) : 32'h0);
    if (ed) begin
      chk({tag, " m_addr"}, m_addr, da);
      chk({tag, " m_wd"}, m_wd, dwd);
    end else begin
      if (!ei) chk({tag, " m_wd"}, m_wd, 32'h0);
      if (!r) chk({tag, " m_addr"}, m_addr, ia);
    end
    if (ei && !drop) iq.push_back('{cyc + 1, iv});
    if (ed && !drop) dq.push_back('{cyc + 1, dv});
    @(posedge clk);
    #1;
  endtask

  bit [0:11] pat_contend = 12'b1111_0111_1011;
  bit [0:4]  pat_after   = 5'b11110;

  initial begin
    int ik, dk;
    rst = 1'b1; i_req = 1'b0; d_req = 1'b0;
    i_addr = 32'h0; d_addr = 32'h0; d_wd = 32'h0; d_we = 4'h0;
    @(posedge clk);
    #1;

    // Reset with both requesters active, including a store to 0x40.
    step(1, 1, 32'h0, 1, 4'hF, 32'h40, 32'hFFFF_FFFF, 0, 0, 0, 0, 0, "reset0");
    step(1, 1, 32'h4, 1, 4'hF, 32'h40, 32'hFFFF_FFFF, 0, 0, 0, 0, 0, "reset1");

    // Fetch only.
    step(0, 1, 32'h000, 0, 4'h0, 32'h0, 32'h0, 1, 0, 32'h11, 0, 0, "fetch0");
    step(0, 1, 32'h004, 0, 4'h0, 32'h0, 32'h0, 1, 0, 32'h22, 0, 0, "fetch1");
    step(0, 1, 32'h008, 0, 4'h0, 32'h0, 32'h0, 1, 0, 32'h33, 0, 0, "fetch2");

    // Partial store then load back; store ack returns the old word.
    step(0, 0, 32'h0, 1, 4'b0011, 32'h40, 32'hAAAA_BBBB, 0, 1, 0, 32'h1234_5678, 0, "store40");
    step(0, 0, 32'h0, 1, 4'b0000, 32'h40, 32'h0, 0, 1, 0, 32'h1234_BBBB, 0, "load40");

    // Contention: both held for 12 cycles -> D,D,D,D,I repeating.
    ik = 0; dk = 0;
    for (int c = 0; c < 12; c++) begin
      step(0, 1, 32'(32'h200 + 4*ik), 1, 4'h0, 32'(32'h100 + 4*dk), 32'h0,
           !pat_contend[c], pat_contend[c],
           32'(32'hA000_0080 + ik), 32'(32'hA000_0040 + dk), 0, "contend");
      if (pat_contend[c]) dk++; else ik++;
    end

    // Data only for 6 cycles; fetch idle clears the starvation count.
    for (int k = 0; k < 6; k++)
      step(0, 0, 32'h0, 1, 4'h0, 32'(32'h300 + 4*k), 32'h0, 0, 1,
           0, 32'(32'hA000_00C0 + k), 0, "donly");

    // Contention again from a cleared count: four data grants then fetch.
    dk = 0;
    for (int c = 0; c < 5; c++) begin
      step(0, 1, 32'h000, 1, 4'h0, 32'(32'h180 + 4*dk), 32'h0,
           !pat_after[c], pat_after[c], 32'h11, 32'(32'hA000_0060 + dk), 0, "recont");
      if (pat_after[c]) dk++;
    end

    // Load granted, then reset next cycle: its response is dropped, and a
    // store presented during reset must not reach memory.
    step(0, 0, 32'h0, 1, 4'h0, 32'h84, 32'h0, 0, 1, 0, 0, 1, "prerst");
    step(1, 1, 32'h8, 1, 4'hF, 32'h80, 32'hDEAD_BEEF, 0, 0, 0, 0, 0, "midrst");
    step(0, 0, 32'h0, 1, 4'h0, 32'h80, 32'h0, 0, 1, 0, 32'hCAFE_F00D, 0, "postrst");
    step(0, 1, 32'h8, 0, 4'h0, 32'h0, 32'h0, 1, 0, 32'h33, 0, 0, "fetchpost");

    // Reset-time store to 0x40 earlier must not have landed either.
    step(0, 0, 32'h0, 1, 4'h0, 32'h40, 32'h0, 0, 1, 0, 32'h1234_BBBB, 0, "reload40");

    step(0, 0, 32'h0, 0, 4'h0, 32'h0, 32'h0, 0, 0, 0, 0, 0, "idle0");
    step(0, 0, 32'h0, 0, 4'h0, 32'h0, 32'h0, 0, 0, 0, 0, 0, "idle1");

    chk("iq_drained", 32'(iq.size()), 32'h0);
    chk("dq_drained", 32'(dq.size()), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d passed so far", n_pass, n_total);
    $fatal(1, "watchdog expired");
  end

endmodule
